// File: rtl/perf_counter_bank.sv
// Performance counter bank: NUM_CH event counters plus a cycle counter, gated by an IDLE/RUN/FROZEN FSM,
// with a fully pipelined 1-cycle read port. Define PERF_SATURATE_EN to saturate instead of wrap on overflow.
module perf_counter_bank #(
  parameter int NUM_CH = 5,
  parameter int CNT_W  = 32,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] event_in,
  input  logic              start,
  input  logic              halt,
  input  logic              clr,
  input  logic              rd_req,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic              rd_ack,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_err,
  output logic              running,
  output logic [NUM_CH:0]   ovf
);

  localparam int                NCNT     = NUM_CH + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [SEL_W-1:0]  CYC_SEL  = SEL_W'(NUM_CH);

  typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q [NCNT];
  logic [CNT_W-1:0]  cnt_d [NCNT];
  logic [NUM_CH:0]   ovf_q, ovf_d;
  logic [NUM_CH:0]   inc;
  logic              rd_ack_q, rd_ack_d;
  logic              rd_err_q, rd_err_d;
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (halt)  state_d = FROZEN;
        FROZEN:  state_d = FROZEN;
        default: state_d = IDLE;
      endcase
    end
  end

  // The halt cycle itself still counts; only the following cycles are frozen.
  assign inc = (state_q == RUN && !clr) ? {1'b1, event_in} : '0;

  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < NCNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (inc[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
`ifdef PERF_SATURATE_EN
          cnt_d[i] = CNT_MAX;
`else
          cnt_d[i] = '0;
`endif
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Read path samples pre-update counter values, so a read alongside clr returns the old count.
  always_comb begin
    rd_ack_d  = rd_req;
    rd_err_d  = rd_req && (rd_sel > CYC_SEL);
    rd_data_d = '0;
    if (rd_req) begin
      for (int i = 0; i < NCNT; i++) begin
        if (rd_sel == SEL_W'(i)) rd_data_d = cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ovf_q     <= '0;
      rd_ack_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      rd_data_q <= '0;
      for (int i = 0; i < NCNT; i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ovf_q     <= ovf_d;
      rd_ack_q  <= rd_ack_d;
      rd_err_q  <= rd_err_d;
      rd_data_q <= rd_data_d;
      for (int i = 0; i < NCNT; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign rd_ack  = rd_ack_q;
  assign rd_err  = rd_err_q;
  assign rd_data = rd_data_q;
  assign running = (state_q == RUN);
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank (NUM_CH=5, CNT_W=8): directed scenarios plus randomized traffic
// against a behavioural count model. Expected overflow behaviour follows PERF_SATURATE_EN.
module tb_perf_counter_bank;

  localparam int NUM_CH = 5;
  localparam int CNT_W  = 8;
  localparam int SEL_W  = 3;
  localparam int MAXV   = (1 << CNT_W) - 1;
`ifdef PERF_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] event_in;
  logic              start, halt, clr, rd_req;
  logic [SEL_W-1:0]  rd_sel;
  logic              rd_ack, rd_err, running;
  logic [CNT_W-1:0]  rd_data;
  logic [NUM_CH:0]   ovf;

  perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .event_in(event_in), .start(start), .halt(halt), .clr(clr),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(rd_ack), .rd_data(rd_data), .rd_err(rd_err),
    .running(running), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: mode 0=idle, 1=counting, 2=frozen; counts as plain integers.
  int         m_mode;
  int         m_cnt [NUM_CH+1];
  logic [NUM_CH:0] m_ovf;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_ovf  = '0;
    for (int i = 0; i <= NUM_CH; i++) m_cnt[i] = 0;
  endtask

  task automatic cyc(input logic [NUM_CH-1:0] ev, input logic st, input logic hl,
                     input logic cl, input logic rq, input logic [SEL_W-1:0] sel);
    logic            e_ack, e_err;
    logic [CNT_W-1:0] e_data;
    int              add;
    event_in = ev; start = st; halt = hl; clr = cl; rd_req = rq; rd_sel = sel;
    e_ack  = rq;
    e_err  = rq && (int'(sel) > NUM_CH);
    e_data = (rq && int'(sel) <= NUM_CH) ? CNT_W'(m_cnt[sel]) : '0;
    if (cl) begin
      model_reset();
    end else begin
      if (m_mode == 1) begin
        for (int i = 0; i <= NUM_CH; i++) begin
          add = (i == NUM_CH) ? 1 : int'(ev[i]);
          if (m_cnt[i] + add > MAXV) begin
            m_ovf[i] = 1'b1;
            m_cnt[i] = SAT ? MAXV : 0;
          end else begin
            m_cnt[i] = m_cnt[i] + add;
          end
        end
      end
      if (m_mode == 0 && st) m_mode = 1;
      else if (m_mode == 1 && hl) m_mode = 2;
    end
    @(posedge clk);
    #1;
    chk_val("rd_ack", rd_ack, e_ack);
    chk_val("rd_err", rd_err, e_err);
    chk_val("rd_data", rd_data, e_data);
    chk_val("running", running, m_mode == 1);
    chk_val("ovf", ovf, m_ovf);
  endtask

  task automatic idle_cyc();
    cyc('0, 0, 0, 0, 0, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    event_in = '0; start = 0; halt = 0; clr = 0; rd_req = 0; rd_sel = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_val("rst_ack", rd_ack, 0);
    chk_val("rst_data", rd_data, 0);
    chk_val("rst_err", rd_err, 0);
    chk_val("rst_running", running, 0);
    chk_val("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Start, 10 counting cycles, then halt (which also counts).
    cyc(5'b00101, 1, 0, 0, 0, '0);
    repeat (10) cyc(5'b00101, 0, 0, 0, 0, '0);
    cyc(5'b00101, 0, 1, 0, 0, '0);
    chk_val("t35_running", running, 0);
    cyc(5'b11111, 0, 0, 0, 1, 3'd0); chk_val("t35_c0", rd_data, 11);
    cyc(5'b11111, 0, 0, 0, 1, 3'd1); chk_val("t35_c1", rd_data, 0);
    cyc(5'b11111, 0, 0, 0, 1, 3'd2); chk_val("t35_c2", rd_data, 11);
    cyc(5'b11111, 0, 0, 0, 1, 3'd4); chk_val("t35_c4", rd_data, 0);
    cyc(5'b11111, 0, 0, 0, 1, 3'd5); chk_val("t35_cyc", rd_data, 11);
    cyc(5'b00000, 1, 0, 0, 0, '0);
    chk_val("t35_frozen_start", running, 0);

    // Back-to-back reads during counting.
    cyc('0, 0, 0, 1, 0, '0);
    cyc(5'b00001, 1, 0, 0, 0, '0);
    repeat (4) cyc(5'b00001, 0, 0, 0, 0, '0);
    cyc(5'b00001, 0, 0, 0, 1, 3'd0); chk_val("t36_r0", rd_data, 4);
    cyc(5'b00001, 0, 0, 0, 1, 3'd0); chk_val("t36_r1", rd_data, 5);
    cyc(5'b00001, 0, 0, 0, 1, 3'd0); chk_val("t36_r2", rd_data, 6);
    chk_val("t36_ack", rd_ack, 1);

    // 256 events on channel 1 at CNT_W=8.
    cyc('0, 0, 0, 1, 0, '0);
    cyc(5'b00010, 1, 0, 0, 0, '0);
    repeat (255) cyc(5'b00010, 0, 0, 0, 0, '0);
    cyc(5'b00010, 0, 1, 0, 0, '0);
    cyc('0, 0, 0, 0, 1, 3'd1);
    chk_val("t37_data", rd_data, SAT ? 8'hFF : 8'h00);
    chk_val("t37_ovf1", ovf[1], 1);

    // Out-of-range select.
    cyc('0, 0, 0, 0, 1, 3'd7);
    chk_val("t38_ack", rd_ack, 1);
    chk_val("t38_err", rd_err, 1);
    chk_val("t38_data", rd_data, 0);
    cyc('0, 0, 0, 0, 1, 3'd6);
    chk_val("t38_err6", rd_err, 1);

    // clr + start + read in one cycle returns the pre-clear count.
    cyc('0, 0, 0, 1, 0, '0);
    cyc(5'b00001, 1, 0, 0, 0, '0);
    repeat (9) cyc(5'b00001, 0, 0, 0, 0, '0);
    cyc(5'b00001, 1, 0, 1, 1, 3'd0);
    chk_val("t39_data", rd_data, 9);
    chk_val("t39_idle", running, 0);
    cyc(5'b00001, 0, 0, 0, 1, 3'd0);
    chk_val("t39_cleared", rd_data, 0);

    // Asynchronous reset between edges with a read in flight.
    cyc('0, 1, 0, 0, 0, '0);
    repeat (3) cyc(5'b10101, 0, 0, 0, 0, '0);
    cyc(5'b10101, 0, 0, 0, 1, 3'd5);
    chk_val("t40_pre_ack", rd_ack, 1);
    #2;
    rst_n = 1'b0;
    event_in = '0; start = 0; halt = 0; clr = 0; rd_req = 0; rd_sel = '0;
    model_reset();
    #1;
    chk_val("t40_ack", rd_ack, 0);
    chk_val("t40_data", rd_data, 0);
    chk_val("t40_err", rd_err, 0);
    chk_val("t40_running", running, 0);
    chk_val("t40_ovf", ovf, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cyc();
    chk_val("t40_no_ack", rd_ack, 0);
    cyc('0, 1, 0, 0, 1, 3'd5);
    chk_val("t40_post_run", running, 1);
    chk_val("t40_post_cyc", rd_data, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cyc(NUM_CH'($urandom),
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 15) == 0,
          $urandom_range(0, 199) == 0,
          $urandom_range(0, 1) == 1,
          SEL_W'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 5, meaning number of event channels (2..15).
REQ-002 SHALL have parameter CNT_W, default 32, meaning counter width in bits (8..32).
REQ-003 SHALL have parameter SEL_W, default 3, meaning read-select width; 2**SEL_W >= NUM_CH+1 is required.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset; asynchronous, active-low.
REQ-006 SHALL have port event_in, input, NUM_CH, meaning per-channel event pulses (retire, I/D cache req/hit), sampled each cycle.
REQ-007 SHALL have port start, input, 1, meaning a request to begin counting.
REQ-008 SHALL have port halt, input, 1, meaning the processor halted; this freezes counting.
REQ-009 SHALL have port clr, input, 1, meaning a synchronous clear of all counters and flags.
REQ-010 SHALL have port rd_req, input, 1, meaning a read request, sampled each cycle.
REQ-011 SHALL have port rd_sel, input, SEL_W, meaning the counter index; 0..NUM_CH-1 select event counters, NUM_CH selects the cycle counter.
REQ-012 SHALL have port rd_ack, output, 1, meaning read data is valid.
REQ-013 SHALL have port rd_data, output, CNT_W, meaning the read value.
REQ-014 SHALL have port rd_err, output, 1, meaning an out-of-range rd_sel; qualified by rd_ack.
REQ-015 SHALL have port running, output, 1, meaning the FSM is in RUN.
REQ-016 SHALL have port ovf, output, NUM_CH+1, meaning sticky overflow flags; bit NUM_CH belongs to the cycle counter.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and FROZEN.
REQ-018 SHALL apply these transitions: IDLE->RUN on start; RUN->FROZEN on halt; any state->IDLE on clr; all other inputs hold the state.
REQ-019 SHALL give clr priority over start and halt in the same cycle; start in RUN or FROZEN and halt in IDLE or FROZEN are ignored.
REQ-020 SHALL, in RUN, add event_in[i] (0 or 1) to counter i each cycle and add 1 to the cycle counter each cycle.
REQ-021 SHALL count the events and the cycle of the halt cycle itself, with no counting from the next cycle onward.
REQ-022 SHALL hold all counters in IDLE and FROZEN, except for clr.
REQ-023 SHALL, on clr, zero all counters and ovf on the next edge; events in the clr cycle are not counted.
REQ-024 SHALL, when rd_req=1 at edge N, assert rd_ack for exactly the cycle after edge N, with rd_data = the selected counter's value before edge N's update.
REQ-025 SHALL accept rd_req every cycle with fully pipelined 1-cycle latency and no backpressure.
REQ-026 SHALL, when rd_sel > NUM_CH, return rd_data=0 and rd_err=1 with rd_ack; otherwise rd_err=0.
REQ-027 SHALL hold rd_data=0 and rd_err=0 whenever rd_ack=0.
REQ-028 SHALL, for rd_req together with clr, return the pre-clear value.
REQ-029 SHALL set ovf[i] when counter i is incremented while at all-ones; ovf stays set until clr or reset.

Reset
REQ-030 SHALL, while rst_n=0, immediately force state=IDLE, all counters=0, ovf=0, rd_ack=0, rd_data=0, rd_err=0 and running=0, independent of clk.
REQ-031 SHALL drop any pending read on reset mid-read; no rd_ack is produced after rst_n deasserts.
REQ-032 SHALL leave the first post-reset edge behaving as normal IDLE operation.

Configuration
REQ-033 SHALL, with macro PERF_SATURATE_EN defined, hold an overflowing counter at all-ones (2**CNT_W-1).
REQ-034 SHALL, without PERF_SATURATE_EN, wrap an overflowing counter to 0; ovf is set in both builds.

Verification
REQ-035 SHALL cover: reset, start, 10 cycles with event_in=5'b00101, then halt -> counters 0 and 2 = 11, others 0, cycle counter 11, running=0.
REQ-036 SHALL cover: rd_req with rd_sel=0 on three consecutive cycles during RUN with event_in[0]=1, value 4 at first sample -> rd_ack on 3 cycles with rd_data 4, 5, 6.
REQ-037 SHALL cover: CNT_W=8, 256 events on channel 1 -> with PERF_SATURATE_EN rd_data=0xFF and ovf[1]=1; without it rd_data=0x00 and ovf[1]=1.
REQ-038 SHALL cover: rd_sel=7 with NUM_CH=5 -> rd_ack=1, rd_err=1, rd_data=0.
REQ-039 SHALL cover: clr, start and rd_req(sel=0) in the same cycle with counter 0 at 9 -> rd_data=9, state IDLE, counter 0=0.
REQ-040 SHALL cover: rst_n low mid-RUN between edges -> outputs 0 before the next clk edge, and no rd_ack after release.
